// File: rtl/ef_smsdac_enc.sv
// Segmented mismatch-shaping DAC encoder: error-feedback requantiser with LFSR dither,
// followed by a toggle-driven tree that splits each level into NSEG 3-level elements.
module ef_smsdac_enc #(
    parameter int unsigned W    = 8,
    parameter int unsigned NSEG = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_b,
    input  logic [W-1:0]      i_x,
    input  logic              i_en_enc,
    input  logic              i_en_dith,
    output logic [2*NSEG-1:0] o_y,
    output logic              o_sat
);

    localparam int unsigned D  = W - NSEG - 1;
    localparam int unsigned EW = (D > 0) ? D : 1;
    localparam int unsigned AW = W + 2;
    localparam int unsigned QW = NSEG + 1;

    localparam logic signed [AW-1:0] HALF  = AW'(1 << (W - 1));
    localparam logic signed [AW-1:0] CAP_A = AW'((1 << NSEG) - 1);
    localparam logic signed [QW-1:0] CAP_Q = QW'((1 << NSEG) - 1);
    localparam logic signed [QW-1:0] P1    = QW'(1);
    localparam logic signed [QW-1:0] M1    = QW'(-1);

    logic [W-1:0]         x_r;
    logic [EW-1:0]        e_q, e_d;
    logic signed [QW-1:0] q_r, q_d;
    logic                 sat_r, sat_d;
    logic [15:0]          lfsr_q, lfsr_d;
    logic signed [AW-1:0] acc, q_full;

    logic [NSEG-1:0]      t_q, t_d;
    logic [2*NSEG-1:0]    y_d;
    logic signed [QW-1:0] rem, s_k, cap_k, mag;
    logic                 odd, forced;

    // Fibonacci form, taps 16,14,13,11 mapped onto a right-shifting register
    assign lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

    always_comb begin
        acc = $signed({2'b00, x_r}) - HALF
            + $signed({{(AW - EW){1'b0}}, e_q})
            + $signed({{(AW - 1){1'b0}}, i_en_dith & lfsr_q[0]});
        q_full = acc >>> D;
        q_d    = q_full[QW-1:0];
        e_d    = (D > 0) ? acc[EW-1:0] : '0;
        sat_d  = 1'b0;
        if (q_full > CAP_A) begin
            q_d   = CAP_Q;
            e_d   = '0;
            sat_d = 1'b1;
        end else if (q_full < -CAP_A) begin
            q_d   = -CAP_Q;
            e_d   = '0;
            sat_d = 1'b1;
        end
    end

    // Each stage peels off one +-1 element and halves the exact remainder
    always_comb begin
        rem    = q_r;
        t_d    = t_q;
        y_d    = '0;
        s_k    = '0;
        cap_k  = '0;
        mag    = '0;
        odd    = 1'b0;
        forced = 1'b0;
        for (int k = 0; k < NSEG; k++) begin
            cap_k  = QW'((1 << (NSEG - k)) - 1);
            mag    = rem[QW-1] ? -rem : rem;
            odd    = rem[0];
            forced = odd && (mag == cap_k);
            if (!odd) begin
                s_k = '0;
            end else if (forced || !i_en_enc) begin
                s_k = rem[QW-1] ? M1 : P1;
            end else begin
                s_k    = t_q[k] ? M1 : P1;
                t_d[k] = ~t_q[k];
            end
            y_d[2*k+1] = odd && !s_k[QW-1];
            y_d[2*k]   = odd && s_k[QW-1];
            rem        = (rem - s_k) >>> 1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            x_r    <= '0;
            e_q    <= '0;
            q_r    <= '0;
            sat_r  <= 1'b0;
            lfsr_q <= 16'hACE1;
            t_q    <= '0;
            o_y    <= '0;
            o_sat  <= 1'b0;
        end else begin
            x_r    <= i_x;
            e_q    <= e_d;
            q_r    <= q_d;
            sat_r  <= sat_d;
            lfsr_q <= lfsr_d;
            t_q    <= t_d;
            o_y    <= y_d;
            o_sat  <= sat_r;
        end
    end

endmodule

// File: tb/tb_ef_smsdac_enc.sv
// Bench for ef_smsdac_enc: three parameterisations against an arithmetic reference model,
// plus hand-computed expectations for the default (8,4) instance.
module tb_ef_smsdac_enc;

    logic       clk = 1'b0;
    logic       rst_b = 1'b0;
    logic       en_enc, en_dith;
    logic [7:0] x0;
    logic [9:0] x1;
    logic [5:0] x2;
    logic [7:0] y0;
    logic [9:0] y1, y2;
    logic       sat0, sat1, sat2;
    logic [9:0] yd [3];

    int n_cmp = 0;
    int n_bad = 0;

    int pw [3] = '{8, 10, 6};
    int pn [3] = '{4, 5, 5};

    // Reference model state, one slot per instance
    int          m_x [3], m_e [3], m_q [3], m_sat [3];
    int          m_y [3], m_osat [3], m_qout [3];
    int          m_t [3][5];
    logic [15:0] m_lfsr [3];

    always #5 clk = ~clk;

    ef_smsdac_enc #(.W(8), .NSEG(4)) dut0 (
        .i_clk(clk), .i_rst_b(rst_b), .i_x(x0), .i_en_enc(en_enc), .i_en_dith(en_dith),
        .o_y(y0), .o_sat(sat0)
    );
    ef_smsdac_enc #(.W(10), .NSEG(5)) dut1 (
        .i_clk(clk), .i_rst_b(rst_b), .i_x(x1), .i_en_enc(en_enc), .i_en_dith(en_dith),
        .o_y(y1), .o_sat(sat1)
    );
    ef_smsdac_enc #(.W(6), .NSEG(5)) dut2 (
        .i_clk(clk), .i_rst_b(rst_b), .i_x(x2), .i_en_enc(en_enc), .i_en_dith(en_dith),
        .o_y(y2), .o_sat(sat2)
    );

    assign yd[0] = {2'b00, y0};
    assign yd[1] = y1;
    assign yd[2] = y2;

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     nm, act, act, exp, exp, $time);
        end
    endtask

    function automatic int dec(input logic [9:0] y, input int n);
        int s;
        s = 0;
        for (int k = 0; k < n; k++) begin
            if (y[2*k+1] && !y[2*k]) s += (1 << k);
            else if (!y[2*k+1] && y[2*k]) s -= (1 << k);
        end
        return s;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_x[i] = 0; m_e[i] = 0; m_q[i] = 0; m_sat[i] = 0;
            m_y[i] = 0; m_osat[i] = 0; m_qout[i] = 0;
            m_lfsr[i] = 16'hACE1;
            for (int k = 0; k < 5; k++) m_t[i][k] = 0;
        end
    endtask

    task automatic model_step();
        int r, s, cap, yv, p, v, acc, q, d;
        for (int i = 0; i < 3; i++) begin
            // output stage: split the held level into signed powers of two
            r  = m_q[i];
            yv = 0;
            for (int k = 0; k < pn[i]; k++) begin
                cap = (1 << (pn[i] - k)) - 1;
                if (r % 2 == 0) s = 0;
                else if (r == cap || r == -cap || !en_enc) s = (r > 0) ? 1 : -1;
                else begin
                    s = m_t[i][k] ? -1 : 1;
                    m_t[i][k] = 1 - m_t[i][k];
                end
                if (s == 1) yv |= 1 << (2*k+1);
                else if (s == -1) yv |= 1 << (2*k);
                r = (r - s) / 2;
            end
            m_y[i]    = yv;
            m_osat[i] = m_sat[i];
            m_qout[i] = m_q[i];
            // requantiser with floor division and error carry
            p   = 1 << (pw[i] - pn[i] - 1);
            v   = m_x[i] - (1 << (pw[i] - 1));
            d   = en_dith ? int'(m_lfsr[i][0]) : 0;
            acc = v + m_e[i] + d;
            q   = (acc >= 0) ? acc / p : -((-acc + p - 1) / p);
            m_e[i]   = acc - q * p;
            m_sat[i] = 0;
            cap = (1 << pn[i]) - 1;
            if (q > cap) begin q = cap; m_sat[i] = 1; m_e[i] = 0; end
            else if (q < -cap) begin q = -cap; m_sat[i] = 1; m_e[i] = 0; end
            m_q[i] = q;
            m_lfsr[i] = {m_lfsr[i][0] ^ m_lfsr[i][2] ^ m_lfsr[i][3] ^ m_lfsr[i][5],
                         m_lfsr[i][15:1]};
            m_x[i] = (i == 0) ? int'(x0) : (i == 1) ? int'(x1) : int'(x2);
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_b);
        if (!rst_b) model_reset();
        else model_step();
    end

    // Per-cycle comparison: exact codes, saturation flag and the tree sum invariant
    initial forever begin
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("y%0d", i), int'(yd[i]), m_y[i]);
            check($sformatf("sat%0d", i),
                  (i == 0) ? int'(sat0) : (i == 1) ? int'(sat1) : int'(sat2), m_osat[i]);
            check($sformatf("tree_sum%0d", i), dec(yd[i], pn[i]), m_qout[i]);
        end
    end

    task automatic set_x(input logic [7:0] v);
        x0 = v;
        x1 = {v, v[1:0]};
        x2 = v[7:2];
    endtask

    task automatic lit(input string nm, input int ey, input int es);
        check({nm, "_y"}, int'(y0), ey);
        check({nm, "_sat"}, int'(sat0), es);
        check({nm, "_model"}, m_y[0], ey);
    endtask

    int qsum;
    int dev;

    initial begin
        en_enc  = 1'b1;
        en_dith = 1'b0;
        set_x(8'd0);
        repeat (5) begin
            @(negedge clk);
            lit("rst_hold", 'h00, 0);
            set_x(8'($urandom_range(0, 255)));
        end

        // release with full scale: x_r reset to 0 gives one clipped negative level first
        @(negedge clk);
        rst_b = 1'b1;
        set_x(8'd255);
        @(negedge clk); lit("lat1", 'h00, 0);
        @(negedge clk); lit("lat2", 'h55, 1);
        @(negedge clk); lit("fs0", 'hAA, 0);
        @(negedge clk); lit("fs1", 'hAA, 1);
        @(negedge clk); lit("fs2", 'hAA, 0);
        @(negedge clk); lit("fs3", 'hAA, 1);

        set_x(8'd0);
        repeat (3) @(negedge clk);
        lit("zs0", 'h55, 1); @(negedge clk);
        lit("zs1", 'h55, 1); @(negedge clk);
        lit("zs2", 'h55, 1);

        set_x(8'd136);
        repeat (3) @(negedge clk);
        lit("sh0", 'h02, 0); @(negedge clk);
        lit("sh1", 'h09, 0); @(negedge clk);
        lit("sh2", 'h02, 0); @(negedge clk);
        lit("sh3", 'h25, 0);
        en_enc = 1'b0;
        @(negedge clk); lit("st0", 'h02, 0);
        @(negedge clk); lit("st1", 'h02, 0);

        // v=5 at D=3: 64 outputs must sum to 40 within the error-register span
        en_enc = 1'b1;
        set_x(8'd133);
        repeat (3) @(negedge clk);
        qsum = 0;
        for (int n = 0; n < 64; n++) begin
            qsum += dec(yd[0], 4);
            @(negedge clk);
        end
        dev = qsum * 8 - 64 * 5;
        check("mean_track", int'((dev > -8) && (dev < 8)), 1);

        set_x(8'd255);
        repeat (3) @(negedge clk);
        check("pre_rst_y", int'(y0), 'hAA);
        #1 rst_b = 1'b0;
        #1;
        check("async_rst_y0", int'(y0), 0);
        check("async_rst_sat0", int'(sat0), 0);
        check("async_rst_y1", int'(y1), 0);
        @(negedge clk);
        rst_b = 1'b1;

        repeat (400) begin
            set_x(8'($urandom_range(0, 255)));
            en_enc  = 1'($urandom);
            en_dith = 1'($urandom);
            @(negedge clk);
        end

        set_x(8'd128);
        en_dith = 1'b0;
        en_enc  = 1'b1;
        repeat (3) @(negedge clk);
        for (int n = 0; n < 4; n++) begin
            lit("mid", 'h00, 0);
            @(negedge clk);
        end

        @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
